// File: rtl/spram_bus_port_if.sv
// spram_bus_port_if
//   Groups the byte-addressed bus request/response signals together with the
//   16-bit spram read/write port that spram_bus_port drives.
//
//   Parameter:
//     widthad        spram word-address width; the bus byte address is widthad+1 bits
//
//   Signals:
//     req, we, is_word, addr, wdata   bus request (initiator -> port)
//     ack, rdata                      bus completion and read data (port -> initiator)
//     ram_rdaddress                   spram read address (port -> spram)
//     ram_q                           spram read data, one cycle after the address (spram -> port)
//     ram_wraddress, ram_wren, ram_data   spram write port (port -> spram)
//
//   Modports:
//     slave   the spram_bus_port itself
//     master  its environment: the bus mux on one side and the spram on the other
interface spram_bus_port_if #(
  parameter int widthad = 14
);
  logic               req;
  logic               we;
  logic               is_word;
  logic [widthad:0]   addr;
  logic [15:0]        wdata;
  logic               ack;
  logic [15:0]        rdata;
  logic [widthad-1:0] ram_rdaddress;
  logic [15:0]        ram_q;
  logic [widthad-1:0] ram_wraddress;
  logic               ram_wren;
  logic [15:0]        ram_data;

  modport slave (
    input  req, we, is_word, addr, wdata, ram_q,
    output ack, rdata, ram_rdaddress, ram_wraddress, ram_wren, ram_data
  );

  modport master (
    output req, we, is_word, addr, wdata, ram_q,
    input  ack, rdata, ram_rdaddress, ram_wraddress, ram_wren, ram_data
  );
endinterface

// File: rtl/spram_bus_port.sv
// spram_bus_port
//   Converts 8086-style byte-addressed bus accesses into word accesses on a
//   16-bit spram without byte enables. Byte writes are done as
//   read-modify-write; word accesses at odd byte addresses are split across
//   two consecutive RAM words (A0 = addr>>1 and A1 = A0+1, wrapping silently).
//   Data is little-endian: the even byte lives in [7:0], the odd byte in [15:8].
//
//   Ports:
//     clk_i    system clock
//     reset_i  asynchronous active-high reset
//     bus      spram_bus_port_if.slave: bus request/ack/rdata plus the spram port
module spram_bus_port #(
  parameter int widthad = 14
) (
  input  logic             clk_i,
  input  logic             reset_i,
  spram_bus_port_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD0,
    S_RD1,
    S_WR0,
    S_WR1,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic               we_q, we_d;
  logic               is_word_q, is_word_d;
  logic [widthad:0]   addr_q, addr_d;
  logic [15:0]        wdata_q, wdata_d;
  logic [15:0]        buf0_q, buf0_d;
  logic [15:0]        buf1_q, buf1_d;
  logic [15:0]        rdata_q, rdata_d;

  logic [widthad-1:0] a0;
  logic [widthad-1:0] a1;
  logic               split;

  assign a0    = addr_q[widthad:1];
  assign a1    = a0 + {{(widthad-1){1'b0}}, 1'b1};
  assign split = is_word_q & addr_q[0];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      we_q      <= 1'b0;
      is_word_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      buf0_q    <= '0;
      buf1_q    <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      is_word_q <= is_word_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      buf0_q    <= buf0_d;
      buf1_q    <= buf1_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    is_word_d = is_word_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    buf0_d    = buf0_q;
    buf1_d    = buf1_q;
    rdata_d   = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          we_d      = bus.we;
          is_word_d = bus.is_word;
          addr_d    = bus.addr;
          wdata_d   = bus.wdata;
          // An aligned word write replaces the whole word, so no read is needed.
          if (bus.we & bus.is_word & ~bus.addr[0])
            state_d = S_WR0;
          else
            state_d = S_RD0;
        end
      end

      S_RD0: begin
        buf0_d = bus.ram_q;
        if (split) begin
          state_d = S_RD1;
        end else if (we_q) begin
          state_d = S_WR0;
        end else begin
          state_d = S_DONE;
          // ram_q is used directly since buf0 only updates on this same edge.
          if (is_word_q)
            rdata_d = bus.ram_q;
          else if (addr_q[0])
            rdata_d = {8'h00, bus.ram_q[15:8]};
          else
            rdata_d = {8'h00, bus.ram_q[7:0]};
        end
      end

      S_RD1: begin
        buf1_d = bus.ram_q;
        if (we_q) begin
          state_d = S_WR0;
        end else begin
          state_d = S_DONE;
          rdata_d = {bus.ram_q[7:0], buf0_q[15:8]};
        end
      end

      S_WR0:   state_d = split ? S_WR1 : S_DONE;
      S_WR1:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // In IDLE the live bus address goes straight to spram so the read of A0 is
  // launched on the same edge that latches the request. RD0 prefetches A1 for
  // the second half of a split access.
  assign bus.ram_rdaddress = (state_q == S_IDLE) ? bus.addr[widthad:1] :
                             (state_q == S_RD0)  ? a1 : a0;

  assign bus.ack       = (state_q == S_DONE);
  assign bus.rdata     = rdata_q;
  assign bus.ram_wren  = (state_q == S_WR0) || (state_q == S_WR1);
  assign bus.ram_wraddress = (state_q == S_WR1) ? a1 : a0;

  // Merge of new bytes with the preserved bytes of the buffered RAM words.
  // An odd byte write and the low half of a split word write share one form:
  // wdata[7:0] lands in the odd byte of A0.
  assign bus.ram_data = (state_q == S_WR1)             ? {buf1_q[15:8], wdata_q[15:8]} :
                        (is_word_q & ~addr_q[0])       ? wdata_q :
                        (~addr_q[0])                   ? {buf0_q[15:8], wdata_q[7:0]} :
                                                         {wdata_q[7:0], buf0_q[7:0]};

endmodule

// File: tb/tb_spram_bus_port.sv
// tb_spram_bus_port
//   Directed bench for spram_bus_port with a behavioural 16-bit spram model
//   (registered read, write on wren) and a queue of expected completions.
module tb_spram_bus_port;
  localparam int AW = 14;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spram_bus_port_if #(.widthad(AW)) bus_if ();

  spram_bus_port #(.widthad(AW)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus_if)
  );

  // spram model with a backdoor write port for preloading
  logic [15:0]   mem [0:(1<<AW)-1];
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [15:0]   bd_data = '0;
  int            wren_cnt = 0;
  logic [AW-1:0] last_wa = '0;
  logic [15:0]   last_wd = '0;

  always @(posedge clk) begin
    bus_if.ram_q <= mem[bus_if.ram_rdaddress];
    if (bus_if.ram_wren) begin
      mem[bus_if.ram_wraddress] <= bus_if.ram_data;
      wren_cnt <= wren_cnt + 1;
      last_wa  <= bus_if.ram_wraddress;
      last_wd  <= bus_if.ram_data;
    end
    if (bd_we) mem[bd_addr] <= bd_data;
  end

  typedef struct {
    string       tag;
    logic        is_read;
    logic [15:0] rdata;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bd_write(input logic [AW-1:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    bd_addr = a;
    bd_data = d;
    bd_we   = 1'b1;
    @(posedge clk); #1;
    bd_we   = 1'b0;
  endtask

  // Scramble the bus after the request is latched; the access must not notice.
  task automatic scramble();
    bus_if.req     = 1'b0;
    bus_if.we      = 1'($urandom);
    bus_if.is_word = 1'($urandom);
    bus_if.addr    = (AW+1)'($urandom);
    bus_if.wdata   = 16'($urandom);
  endtask

  task automatic push_exp(input string tag, input logic w, input logic [15:0] er, input int el);
    exp_t e;
    e.tag     = tag;
    e.is_read = ~w;
    e.rdata   = er;
    e.lat     = el;
    sb.push_back(e);
  endtask

  task automatic drive(input logic w, input logic iw, input logic [AW:0] a, input logic [15:0] wd);
    bus_if.req     = 1'b1;
    bus_if.we      = w;
    bus_if.is_word = iw;
    bus_if.addr    = a;
    bus_if.wdata   = wd;
  endtask

  task automatic wait_ack();
    exp_t e;
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus_if.ack !== 1'b1 && lat < 20);
    e = sb.pop_front();
    check({e.tag, "_lat"}, 32'(lat), 32'(e.lat));
    if (e.is_read) check({e.tag, "_rdata"}, {16'h0, bus_if.rdata}, {16'h0, e.rdata});
    $display("txn %s: latency=%0d rdata=0x%04h", e.tag, lat, bus_if.rdata);
  endtask

  task automatic access(input string tag, input logic w, input logic iw, input logic [AW:0] a,
                        input logic [15:0] wd, input logic [15:0] er, input int el);
    @(posedge clk); #1;
    drive(w, iw, a, wd);
    push_exp(tag, w, er, el);
    @(posedge clk); #1;
    scramble();
    wait_ack();
  endtask

  initial begin
    int w0;
    int acks;

    reset = 1'b1;
    bus_if.req = 1'b0; bus_if.we = 1'b0; bus_if.is_word = 1'b0;
    bus_if.addr = '0;  bus_if.wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ack",   {31'h0, bus_if.ack},      32'h0);
    check("reset_rdata", {16'h0, bus_if.rdata},    32'h0);
    check("reset_wren",  {31'h0, bus_if.ram_wren}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // aligned word read
    bd_write(14'h10, 16'h1234);
    access("word_rd_20", 1'b0, 1'b1, 15'h20, 16'h0, 16'h1234, 2);

    // odd byte write: one RMW write pulse
    w0 = wren_cnt;
    access("byte_wr_21", 1'b1, 1'b0, 15'h21, 16'h77AB, 16'h0, 3);
    check("byte_wr_pulses", 32'(wren_cnt - w0), 32'd1);
    check("byte_wr_addr",   {18'h0, last_wa},   32'h10);
    check("byte_wr_data",   {16'h0, last_wd},   32'hAB34);
    check("rdata_hold_wr",  {16'h0, bus_if.rdata}, 32'h1234);

    access("byte_rd_21", 1'b0, 1'b0, 15'h21, 16'h0, 16'h00AB, 2);
    access("byte_rd_20", 1'b0, 1'b0, 15'h20, 16'h0, 16'h0034, 2);

    // even byte write, high byte of wdata must be ignored
    access("byte_wr_20", 1'b1, 1'b0, 15'h20, 16'h9955, 16'h0, 3);
    check("byte_wr_20_mem", {16'h0, mem[14'h10]}, 32'hAB55);

    // aligned word write: no read phase
    w0 = wren_cnt;
    access("word_wr_20", 1'b1, 1'b1, 15'h20, 16'h1234, 16'h0, 2);
    check("word_wr_pulses", 32'(wren_cnt - w0), 32'd1);
    check("word_wr_mem", {16'h0, mem[14'h10]}, 32'h1234);

    // split word read and write
    bd_write(14'h11, 16'h5678);
    access("split_rd_21", 1'b0, 1'b1, 15'h21, 16'h0, 16'h7812, 3);
    w0 = wren_cnt;
    access("split_wr_21", 1'b1, 1'b1, 15'h21, 16'hCDEF, 16'h0, 5);
    check("split_wr_pulses", 32'(wren_cnt - w0), 32'd2);
    check("split_wr_mem10", {16'h0, mem[14'h10]}, 32'hEF34);
    check("split_wr_mem11", {16'h0, mem[14'h11]}, 32'h56CD);

    // wrap from the last word to word 0
    bd_write(14'h3FFF, 16'h1122);
    bd_write(14'h0000, 16'h3344);
    access("wrap_wr_7fff", 1'b1, 1'b1, 15'h7FFF, 16'hBEEF, 16'h0, 5);
    check("wrap_mem3fff", {16'h0, mem[14'h3FFF]}, 32'hEF22);
    check("wrap_mem0000", {16'h0, mem[14'h0000]}, 32'h33BE);
    access("wrap_rd_7fff", 1'b0, 1'b1, 15'h7FFF, 16'h0, 16'hBEEF, 3);

    // back-to-back reads with req held high
    bd_write(14'h0000, 16'h1111);
    bd_write(14'h0001, 16'h2222);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 15'h00, 16'h0);
    push_exp("b2b_first", 1'b0, 16'h1111, 2);
    @(posedge clk); #1;
    bus_if.addr = 15'h02;              // ignored while busy, used by the next access
    wait_ack();                        // ack in cycle 2
    @(negedge clk);                    // cycle 3: IDLE, req still high
    check("b2b_gap_ack",   {31'h0, bus_if.ack},   32'h0);
    check("b2b_gap_rdata", {16'h0, bus_if.rdata}, 32'h1111);
    push_exp("b2b_second", 1'b0, 16'h2222, 2);
    @(posedge clk); #1;
    scramble();
    wait_ack();                        // ack in cycle 5

    // reset during WR0 of a split write
    bd_write(14'h10, 16'h1234);
    bd_write(14'h11, 16'h5678);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 15'h21, 16'hCDEF);
    @(posedge clk); #1;
    scramble();
    repeat (3) @(negedge clk);         // cycles 1 (RD0), 2 (RD1), 3 (WR0)
    check("rst_mid_wr0_wren", {31'h0, bus_if.ram_wren}, 32'h1);
    reset = 1'b1;
    #1;
    check("rst_mid_wren",  {31'h0, bus_if.ram_wren}, 32'h0);
    check("rst_mid_rdata", {16'h0, bus_if.rdata},    32'h0);
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus_if.ack === 1'b1 || bus_if.ram_wren === 1'b1) acks++;
    end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus_if.ack === 1'b1 || bus_if.ram_wren === 1'b1) acks++;
    end
    check("rst_mid_no_ack_wren", 32'(acks), 32'd0);
    check("rst_mid_mem11", {16'h0, mem[14'h11]}, 32'h5678);
    access("post_rst_rd_22", 1'b0, 1'b1, 15'h22, 16'h0, 16'h5678, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
